// File: rtl/simple_cache_pkg.sv
// Shared widths, line/address types and the address-split helper for the simple cache.
// Build option: CACHE_READ_ALLOCATE_EN (read misses also install a zero-data line).
package simple_cache_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_NUM_LINES  = 256;
  localparam int DEFAULT_TAG_WIDTH  = 10;
  localparam int DEFAULT_INDEX_W    = $clog2(DEFAULT_NUM_LINES);

  typedef logic [DEFAULT_TAG_WIDTH-1:0]  tag_t;
  typedef logic [DEFAULT_INDEX_W-1:0]    index_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t data;
  } cache_line_t;

  typedef struct packed {
    tag_t   tag;
    index_t index;
  } addr_fields_t;

  // Bits above tag+index are dropped, so distant addresses alias onto the same line.
  function automatic addr_fields_t split_addr(input addr_t addr);
    addr_fields_t f;
    f.index = addr[DEFAULT_INDEX_W-1:0];
    f.tag   = addr[DEFAULT_INDEX_W+DEFAULT_TAG_WIDTH-1:DEFAULT_INDEX_W];
    return f;
  endfunction

endpackage

// File: rtl/scc_line_store.sv
// Line storage for the simple cache: valid/tag/data per line, one async read port, one write port.
// Only the valid bits are reset; tag and data contents are don't-care until a line is installed.
module scc_line_store
  import simple_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH,
  parameter int NUM_LINES  = DEFAULT_NUM_LINES,
  parameter int INDEX_W    = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES];

  // Every install marks the line valid; nothing ever invalidates a line except reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/simple_cache_controller.sv
// Direct-mapped, one-word-per-line, write-allocate cache with registered hit/miss/read_data.
// Build option: CACHE_READ_ALLOCATE_EN makes read misses install {valid, tag, 0}.
module simple_cache_controller
  import simple_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_LINES  = DEFAULT_NUM_LINES,
  parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  hit,
  output logic                  miss
);

  localparam int INDEX_W = $clog2(NUM_LINES);

  logic [INDEX_W-1:0]    index;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  line_valid;
  logic [TAG_WIDTH-1:0]  line_tag;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  match;
  logic                  store_en;
  logic [DATA_WIDTH-1:0] store_data;

  assign index = addr[INDEX_W-1:0];
  assign tag   = addr[INDEX_W+TAG_WIDTH-1:INDEX_W];

  generate
    if (INDEX_W + TAG_WIDTH < ADDR_WIDTH) begin : g_alias_bits
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[ADDR_WIDTH-1:INDEX_W+TAG_WIDTH];
    end
  endgenerate

  scc_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .INDEX_W    (INDEX_W)
  ) u_line_store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (store_en),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (store_data)
  );

  assign match = line_valid && (line_tag == tag);

  // Write wins over read; with read-allocate a read miss installs a zeroed line.
`ifdef CACHE_READ_ALLOCATE_EN
  assign store_en   = write || (read && !match);
  assign store_data = write ? write_data : '0;
`else
  assign store_en   = write;
  assign store_data = write_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else if (write) begin
      hit  <= match;
      miss <= !match;
    end else if (read) begin
      hit       <= match;
      miss      <= !match;
      read_data <= match ? line_data : '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_cache_controller.sv
// Bench for simple_cache_controller: directed scenarios then random traffic against a map-based model.
// Honours CACHE_READ_ALLOCATE_EN in the model the same way the design build does.
module tb_simple_cache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        read;
  logic        write;
  logic [31:0] read_data;
  logic        hit;
  logic        miss;

  int total = 0;
  int bad   = 0;

  // Model: a line exists in the map only once installed; key is the line index.
  int unsigned model_tag  [int];
  logic [31:0] model_data [int];
  logic [31:0] exp_rd;

  simple_cache_controller dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .read       (read),
    .write      (write),
    .read_data  (read_data),
    .hit        (hit),
    .miss       (miss)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, input string tag);
    int          idx;
    int unsigned tg;
    bit          present;
    bit          e_hit;
    bit          e_miss;
    @(negedge clk);
    read       = rd;
    write      = wr;
    addr       = a;
    write_data = d;
    idx     = int'(a % 256);
    tg      = (a / 256) % 1024;
    present = model_tag.exists(idx) && (model_tag[idx] == tg);
    e_hit   = 1'b0;
    e_miss  = 1'b0;
    if (wr) begin
      e_hit  = present;
      e_miss = !present;
      model_tag[idx]  = tg;
      model_data[idx] = d;
    end else if (rd) begin
      e_hit  = present;
      e_miss = !present;
      exp_rd = present ? model_data[idx] : 32'h0;
`ifdef CACHE_READ_ALLOCATE_EN
      if (!present) begin
        model_tag[idx]  = tg;
        model_data[idx] = 32'h0;
      end
`endif
    end
    @(posedge clk);
    #1;
    check_output({tag, ".hit"},  {31'b0, hit},  {31'b0, e_hit});
    check_output({tag, ".miss"}, {31'b0, miss}, {31'b0, e_miss});
    check_output({tag, ".rdata"}, read_data, exp_rd);
  endtask

  initial begin
    reset      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    addr       = '0;
    write_data = '0;
    exp_rd     = '0;

    #20;
    check_output("rst.hit",   {31'b0, hit},  32'h0);
    check_output("rst.miss",  {31'b0, miss}, 32'h0);
    check_output("rst.rdata", read_data,     32'h0);
    #30;
    reset = 1'b1;

    apply_stimulus(1, 0, 32'hC, 32'h0, "t1.rdC.a");
    apply_stimulus(1, 0, 32'hC, 32'h0, "t1.rdC.b");

    apply_stimulus(0, 1, 32'hE, 32'hCAFEBABE, "t2.wrE.a");
    apply_stimulus(0, 1, 32'hE, 32'hCAFEBABE, "t2.wrE.b");
    apply_stimulus(1, 0, 32'hB, 32'h0, "t2.rdB");

    apply_stimulus(0, 1, 32'hD, 32'hBABECAFE, "t3.wrD");
    apply_stimulus(1, 0, 32'hD, 32'h0, "t3.rdD");

    apply_stimulus(0, 1, 32'hD, 32'h12345678, "t4.wrD");
    apply_stimulus(1, 0, 32'hD, 32'h0, "t4.rdD");

    apply_stimulus(0, 1, 32'h00D, 32'h1, "t5.wr00D");
    apply_stimulus(0, 1, 32'h10D, 32'h2, "t5.wr10D");
    apply_stimulus(1, 0, 32'h00D, 32'h0, "t5.rd00D");
    apply_stimulus(1, 0, 32'h10D, 32'h0, "t5.rd10D");
    apply_stimulus(1, 1, 32'h20D, 32'h3, "t5.both");
    apply_stimulus(0, 0, 32'h20D, 32'h0, "t5.idle");
    apply_stimulus(1, 0, 32'h20D, 32'h0, "t5.rd20D");

    // Reset lands mid-cycle while a read is held; outputs must clear without waiting for an edge.
    @(negedge clk);
    read  = 1'b1;
    write = 1'b0;
    addr  = 32'hD;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6.rst.hit",   {31'b0, hit},  32'h0);
    check_output("t6.rst.miss",  {31'b0, miss}, 32'h0);
    check_output("t6.rst.rdata", read_data,     32'h0);
    model_tag.delete();
    model_data.delete();
    exp_rd = '0;
    @(negedge clk);
    @(negedge clk);
    read  = 1'b0;
    reset = 1'b1;
    apply_stimulus(1, 0, 32'hD, 32'h0, "t6.rdD");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int unsigned op;
      a  = ($urandom & 32'hFFFC_0000) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 15);
      op = $urandom_range(0, 3);
      apply_stimulus(op[0], op[1], a, $urandom, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
